// File: rtl/ahb_lite_eic_bridge_pkg.sv
// Shared encodings and FSM state type for the AHB-Lite to EIC register bridge.
// Bus encodings follow AMBA AHB-Lite; state order is arbitrary.
package ahb_lite_eic_bridge_pkg;

    localparam int EIC_ADDR_WIDTH = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_lite_eic_bridge_if.sv
// AHB-Lite bus bundle between the decoder/master side and the bridge.
// slave modport is the bridge; master modport drives the transfers.
interface ahb_lite_eic_bridge_if;

    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_lite_eic_bridge.sv
// AHB-Lite slave in front of the EIC register port: zero-wait writes,
// one-wait reads, two-cycle ERROR for illegal transfers.
module ahb_lite_eic_bridge
    import ahb_lite_eic_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = EIC_ADDR_WIDTH,
    parameter int REG_COUNT  = 2 ** ADDR_WIDTH
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_eic_bridge_if.slave  ahb,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [31:0]           read_data,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [31:0]           write_data,
    output logic                  write_enable
);

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic [ADDR_WIDTH-1:0] wr_idx_q;
    logic [31:0]           hrdata_q;
    logic                  ready;
    logic                  accept;
    logic                  illegal;
    logic                  unused_bits;

    assign idx = ahb.HADDR[ADDR_WIDTH+1:2];

    assign illegal = (ahb.HSIZE != HSIZE_WORD)
                   || (ahb.HADDR[1:0] != 2'b00)
                   || (32'(idx) >= 32'(REG_COUNT));

    assign ready = (state == ST_IDLE) || (state == ST_WRITE)
                || (state == ST_RD_DONE) || (state == ST_ERR2);

    assign accept = ready && ahb.HSEL && ahb.HTRANS[1];

    always_comb begin
        state_next = ST_IDLE;
        unique case (state)
            ST_RD_WAIT: state_next = ST_RD_DONE;
            ST_ERR1:    state_next = ST_ERR2;
            default: begin
                if (!accept)
                    state_next = ST_IDLE;
                else if (illegal)
                    state_next = ST_ERR1;
                else if (ahb.HWRITE)
                    state_next = ST_WRITE;
                else
                    state_next = ST_RD_WAIT;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            hrdata_q <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else begin
            state <= state_next;
            if (accept && !illegal) begin
                if (ahb.HWRITE)
                    wr_idx_q <= idx;
                else
                    rd_idx_q <= idx;
            end
            // eic read data is combinational from read_addr; capture it here
            if (state == ST_RD_WAIT)
                hrdata_q <= read_data;
        end
    end

    assign ahb.HRDATA = hrdata_q;
    assign ahb.HREADY = ready;
    assign ahb.HRESP  = (state == ST_ERR1 || state == ST_ERR2)
                      ? HRESP_ERROR : HRESP_OKAY;

    assign read_addr    = rd_idx_q;
    assign write_addr   = wr_idx_q;
    assign write_data   = ahb.HWDATA;
    assign write_enable = (state == ST_WRITE);

    assign unused_bits = ^{ahb.HBURST, ahb.HADDR[31:ADDR_WIDTH+2],
                           ahb.HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_eic_bridge.sv
// Bench for ahb_lite_eic_bridge: vector table, hand sequences and random
// transfers checked against a transaction-level register-file model.
module tb_ahb_lite_eic_bridge;

    localparam int AW = 4;
    localparam int RC = 12;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn;

    always #5 HCLK = ~HCLK;

    ahb_lite_eic_bridge_if bus();

    logic [AW-1:0] read_addr;
    logic [31:0]   read_data;
    logic [AW-1:0] write_addr;
    logic [31:0]   write_data;
    logic          write_enable;

    ahb_lite_eic_bridge #(
        .ADDR_WIDTH(AW),
        .REG_COUNT (RC)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .ahb         (bus.slave),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_enable(write_enable)
    );

    // Stand-in for the eic core register file
    logic [31:0] eic_mem [16] = '{default: 32'h0};

    always @(posedge HCLK)
        if (write_enable) eic_mem[write_addr] <= write_data;

    assign read_data = eic_mem[read_addr];

    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic [31:0] exp_hrdata;
    int checks = 0;
    int errors = 0;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [1:0] tr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        bus.HBURST = 3'($urandom_range(0, 7));
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata);
        int idx;
        bit legal;
        int cycles;
        int strobes;
        logic first_resp;
        logic [31:0] sb_addr;
        logic [31:0] sb_data;
        idx = int'(addr[5:2]);
        legal = (size == 3'b010) && (addr[1:0] == 2'b00) && (idx < RC);
        @(posedge HCLK); #1;
        addr_phase(wr, addr, size, 2'b10);
        @(posedge HCLK); #1;
        idle_bus();
        bus.HWDATA = wdata;
        cycles = 0;
        strobes = 0;
        first_resp = 1'b0;
        sb_addr = '0;
        sb_data = '0;
        do begin
            @(negedge HCLK);
            cycles++;
            if (cycles == 1) first_resp = bus.HRESP;
            if (write_enable) begin
                strobes++;
                sb_addr = 32'(write_addr);
                sb_data = write_data;
            end
        end while (!bus.HREADY && cycles < 8);
        chk("cycles", 32'(cycles), (legal && wr) ? 32'd1 : 32'd2);
        chk("first_resp", 32'(first_resp), 32'(!legal));
        chk("last_resp", 32'(bus.HRESP), 32'(!legal));
        chk("strobes", 32'(strobes), 32'(legal && wr));
        if (strobes > 0) begin
            chk("strobe_addr", sb_addr, 32'(idx));
            chk("strobe_data", sb_data, wdata);
        end
        if (legal && wr) ref_mem[idx] = wdata;
        if (legal && !wr) exp_hrdata = ref_mem[idx];
        chk("hrdata", bus.HRDATA, exp_hrdata);
        err = bus.HRESP;
        rdata = bus.HRDATA;
    endtask

    initial begin
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wd [4];

        vecs[0]  = '{1'b1, 32'h0000_0004, 3'b010, 32'hA5A5_0001, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 3'b010, 32'h0, 1'b0, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 32'h0000_0008, 3'b000, 32'hDEAD_0002, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0006, 3'b010, 32'h0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0030, 3'b010, 32'hDEAD_0004, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_003C, 3'b010, 32'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_002C, 3'b010, 32'h1122_3344, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_002C, 3'b010, 32'h0, 1'b0, 32'h1122_3344};
        vecs[8]  = '{1'b0, 32'h0000_0000, 3'b010, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'hFFFF_FF04, 3'b010, 32'h0, 1'b0, 32'hA5A5_0001};
        vecs[10] = '{1'b1, 32'h0000_0010, 3'b011, 32'hDEAD_000A, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0008, 3'b010, 32'h0, 1'b0, 32'h0};

        HRESETn = 1'b0;
        bus.HADDR = '0;
        bus.HBURST = '0;
        bus.HSIZE = 3'b010;
        bus.HWDATA = '0;
        bus.HWRITE = 1'b0;
        idle_bus();
        exp_hrdata = '0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hready", 32'(bus.HREADY), 32'd1);
        chk("rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].data,
                 err, rdata);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr && !vecs[i].exp_err)
                chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Four pipelined writes: one strobe per cycle, no wait states
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        @(posedge HCLK); #1;
        addr_phase(1'b1, 32'h0, 3'b010, 2'b10);
        for (int i = 1; i <= 4; i++) begin
            @(posedge HCLK); #1;
            if (i < 4) addr_phase(1'b1, 32'(i * 4), 3'b010, 2'b11);
            else idle_bus();
            bus.HWDATA = wd[i-1];
            @(negedge HCLK);
            chk($sformatf("b2b%0d_we", i - 1), 32'(write_enable), 32'd1);
            chk($sformatf("b2b%0d_addr", i - 1), 32'(write_addr), 32'(i - 1));
            chk($sformatf("b2b%0d_data", i - 1), write_data, wd[i-1]);
            chk($sformatf("b2b%0d_hready", i - 1), 32'(bus.HREADY), 32'd1);
            ref_mem[i-1] = wd[i-1];
        end

        // Read pipelined directly behind a write to the same index
        @(posedge HCLK); #1;
        addr_phase(1'b1, 32'h14, 3'b010, 2'b10);
        @(posedge HCLK); #1;
        addr_phase(1'b0, 32'h14, 3'b010, 2'b10);
        bus.HWDATA = 32'h5EED_0005;
        @(negedge HCLK);
        chk("raw_we", 32'(write_enable), 32'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("raw_wait", 32'(bus.HREADY), 32'd0);
        @(negedge HCLK);
        ref_mem[5] = 32'h5EED_0005;
        exp_hrdata = 32'h5EED_0005;
        chk("raw_hready", 32'(bus.HREADY), 32'd1);
        chk("raw_hrdata", bus.HRDATA, exp_hrdata);

        // Reset asserted while a read is waiting
        @(posedge HCLK); #1;
        addr_phase(1'b0, 32'h8, 3'b010, 2'b10);
        @(posedge HCLK); #1;
        idle_bus();
        chk("rw_wait", 32'(bus.HREADY), 32'd0);
        HRESETn = 1'b0;
        #1;
        exp_hrdata = '0;
        chk("rw_rst_hready", 32'(bus.HREADY), 32'd1);
        chk("rw_rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rw_rst_hrdata", bus.HRDATA, 32'd0);
        chk("rw_rst_we", 32'(write_enable), 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        xfer(1'b0, 32'h4, 3'b010, 32'h0, err, rdata);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'b010;
            xfer(1'($urandom_range(0, 1)), a, sz, $urandom, err, rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
